// File: rtl/ara_pkg.sv
// Shared lane types: instruction IDs, mask-owner FU encoding and the owner-queue entry.
package ara_pkg;

    localparam int unsigned NrVInsn  = 8;
    localparam int unsigned VidWidth = $clog2(NrVInsn);

    typedef logic [VidWidth-1:0] vid_t;

    localparam logic MaskFUAlu  = 1'b0;
    localparam logic MaskFUMFpu = 1'b1;

    typedef struct packed {
        logic fu;
        vid_t id;
    } mask_owner_t;

endpackage

// File: rtl/mask_owner_fifo.sv
// In-order FIFO of mask owners; head_o is the current owner when not empty.
module mask_owner_fifo
    import ara_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  mask_owner_t            data_i,
    input  logic                   pop_i,
    output mask_owner_t            head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(Depth):0] count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    mask_owner_t           mem [Depth];
    logic [PtrW-1:0]       wptr;
    logic [PtrW-1:0]       rptr;
    logic [CntW-1:0]       count;
    logic                  push_en;
    logic                  pop_en;

    assign full_o  = (count == CntW'(Depth));
    assign empty_o = (count == '0);
    assign count_o = count;
    assign head_o  = mem[rptr];
    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;

    // Pointers wrap naturally since Depth is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_en) wptr <= wptr + PtrW'(1);
            if (pop_en)  rptr <= rptr + PtrW'(1);
            count <= count + CntW'(push_en) - CntW'(pop_en);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_en) mem[wptr] <= data_i;
    end

endmodule

// File: rtl/vfu_mask_router.sv
// Steers the mask-unit valid/ready handshake to the FU owning the oldest masked instruction.
// Optional protocol checker and sticky error_o enabled by defining ARA_MASK_ROUTER_CHECK_EN.
module vfu_mask_router
    import ara_pkg::*;
#(
    parameter int unsigned MaskQueueDepth = 4,
    parameter int unsigned NrVInsn        = ara_pkg::NrVInsn
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            issue_valid_i,
    input  logic                            issue_fu_i,
    input  vid_t                            issue_id_i,
    output logic                            issue_ready_o,
    input  logic [NrVInsn-1:0]              alu_vinsn_done_i,
    input  logic [NrVInsn-1:0]              mfpu_vinsn_done_i,
    input  logic                            mask_valid_i,
    output logic                            mask_ready_o,
    output logic                            alu_mask_valid_o,
    input  logic                            alu_mask_ready_i,
    output logic                            mfpu_mask_valid_o,
    input  logic                            mfpu_mask_ready_i,
    output logic [$clog2(MaskQueueDepth):0] occupancy_o,
    output logic                            error_o
);

    mask_owner_t head;
    mask_owner_t issue_entry;
    logic        full;
    logic        empty;
    logic        push;
    logic        head_done;
    logic        route;

    assign issue_entry   = '{fu: issue_fu_i, id: issue_id_i};
    assign push          = issue_valid_i && !full;
    assign issue_ready_o = !full;

    mask_owner_fifo #(
        .Depth (MaskQueueDepth)
    ) i_owner_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (issue_entry),
        .pop_i   (head_done),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (occupancy_o)
    );

    // Only a done from the head's own FU for the head's ID retires ownership.
    always_comb begin
        head_done = 1'b0;
        if (!empty) begin
            head_done = (head.fu == MaskFUMFpu) ? mfpu_vinsn_done_i[head.id]
                                                : alu_vinsn_done_i[head.id];
        end
    end

    // Pop and reset cycles are blanked so no beat reaches an outgoing owner.
    assign route = !empty && !head_done && !rst_i;

    always_comb begin
        alu_mask_valid_o  = 1'b0;
        mfpu_mask_valid_o = 1'b0;
        mask_ready_o      = 1'b0;
        if (route) begin
            if (head.fu == MaskFUMFpu) begin
                mfpu_mask_valid_o = mask_valid_i;
                mask_ready_o      = mfpu_mask_ready_i;
            end else begin
                alu_mask_valid_o  = mask_valid_i;
                mask_ready_o      = alu_mask_ready_i;
            end
        end
    end

`ifdef ARA_MASK_ROUTER_CHECK_EN
    logic [NrVInsn-1:0] pend_alu_q;
    logic [NrVInsn-1:0] pend_mfpu_q;
    logic [NrVInsn-1:0] pend_alu_d;
    logic [NrVInsn-1:0] pend_mfpu_d;
    logic [NrVInsn-1:0] head_alu_m;
    logic [NrVInsn-1:0] head_mfpu_m;
    logic               err_push_full;
    logic               err_ooo;
    logic               err_valid_empty;
    logic               error_q;

    // Per-FU bitmaps of queued IDs let out-of-order dones be spotted without scanning.
    always_comb begin
        pend_alu_d  = pend_alu_q;
        pend_mfpu_d = pend_mfpu_q;
        head_alu_m  = '0;
        head_mfpu_m = '0;
        if (!empty) begin
            if (head.fu == MaskFUMFpu) head_mfpu_m[head.id] = 1'b1;
            else                       head_alu_m[head.id]  = 1'b1;
        end
        if (head_done) begin
            pend_alu_d  = pend_alu_d & ~head_alu_m;
            pend_mfpu_d = pend_mfpu_d & ~head_mfpu_m;
        end
        if (push) begin
            if (issue_fu_i == MaskFUMFpu) pend_mfpu_d[issue_id_i] = 1'b1;
            else                          pend_alu_d[issue_id_i]  = 1'b1;
        end
    end

    assign err_push_full   = issue_valid_i && full;
    assign err_ooo         = (|(alu_vinsn_done_i & pend_alu_q & ~head_alu_m)) ||
                             (|(mfpu_vinsn_done_i & pend_mfpu_q & ~head_mfpu_m));
    assign err_valid_empty = mask_valid_i && empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_alu_q  <= '0;
            pend_mfpu_q <= '0;
            error_q     <= 1'b0;
        end else begin
            pend_alu_q  <= pend_alu_d;
            pend_mfpu_q <= pend_mfpu_d;
            error_q     <= error_q || err_push_full || err_ooo || err_valid_empty;
        end
    end

    assign error_o = error_q;

`ifndef SYNTHESIS
    a_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !err_push_full)
        else $error("mask router: issue while owner queue full");
    a_ooo_done: assert property (@(posedge clk_i) disable iff (rst_i) !err_ooo)
        else $error("mask router: out-of-order masked done");
    a_valid_empty: assert property (@(posedge clk_i) disable iff (rst_i) !err_valid_empty)
        else $error("mask router: mask beat with no owner");
`endif
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_vfu_mask_router.sv
// Directed bench for vfu_mask_router: queue-based owner model checked every cycle plus literal expectations.
module tb_vfu_mask_router;
    import ara_pkg::*;

    localparam int unsigned Depth = 4;
    localparam int unsigned OccW  = $clog2(Depth) + 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               issue_valid;
    logic               issue_fu;
    vid_t               issue_id;
    logic               issue_ready;
    logic [NrVInsn-1:0] alu_done;
    logic [NrVInsn-1:0] mfpu_done;
    logic               mask_valid;
    logic               mask_ready;
    logic               alu_mask_valid;
    logic               alu_mask_ready;
    logic               mfpu_mask_valid;
    logic               mfpu_mask_ready;
    logic [OccW-1:0]    occupancy;
    logic               error;

    mask_owner_t mq[$];
    logic        exp_err = 1'b0;
    int          checks   = 0;
    int          failures = 0;
    bit          chk_en   = 1'b0;

    always #5 clk = ~clk;

    vfu_mask_router #(
        .MaskQueueDepth (Depth),
        .NrVInsn        (NrVInsn)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .issue_valid_i     (issue_valid),
        .issue_fu_i        (issue_fu),
        .issue_id_i        (issue_id),
        .issue_ready_o     (issue_ready),
        .alu_vinsn_done_i  (alu_done),
        .mfpu_vinsn_done_i (mfpu_done),
        .mask_valid_i      (mask_valid),
        .mask_ready_o      (mask_ready),
        .alu_mask_valid_o  (alu_mask_valid),
        .alu_mask_ready_i  (alu_mask_ready),
        .mfpu_mask_valid_o (mfpu_mask_valid),
        .mfpu_mask_ready_i (mfpu_mask_ready),
        .occupancy_o       (occupancy),
        .error_o           (error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic done_for(input mask_owner_t e);
        return e.fu ? mfpu_done[e.id] : alu_done[e.id];
    endfunction

    function automatic logic head_done_m();
        if (mq.size() == 0) return 1'b0;
        return done_for(mq[0]);
    endfunction

    // Model: owner list in issue order, updated at each clock edge.
    always @(posedge clk) begin
        bit do_pop;
        bit do_push;
        if (rst) begin
            mq.delete();
            exp_err = 1'b0;
        end else begin
            do_pop  = head_done_m();
            do_push = issue_valid && (mq.size() < Depth);
`ifdef ARA_MASK_ROUTER_CHECK_EN
            if (issue_valid && mq.size() == Depth) exp_err = 1'b1;
            if (mask_valid && mq.size() == 0) exp_err = 1'b1;
            for (int k = 1; k < mq.size(); k++)
                if (done_for(mq[k])) exp_err = 1'b1;
`endif
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back('{fu: issue_fu, id: issue_id});
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        bit          route;
        mask_owner_t h;
        if (chk_en) begin
            route = (mq.size() > 0) && !head_done_m() && !rst;
            h     = (mq.size() > 0) ? mq[0] : '0;
            check("alu_mask_valid", 32'(alu_mask_valid), 32'(route && !h.fu && mask_valid));
            check("mfpu_mask_valid", 32'(mfpu_mask_valid), 32'(route && h.fu && mask_valid));
            check("mask_ready", 32'(mask_ready),
                  32'(route && (h.fu ? mfpu_mask_ready : alu_mask_ready)));
            check("issue_ready", 32'(issue_ready), 32'(mq.size() < Depth));
            check("occupancy", 32'(occupancy), 32'(mq.size()));
            check("error", 32'(error), 32'(exp_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; issue_valid = 1'b0; issue_fu = 1'b0; issue_id = '0;
        alu_done = '0; mfpu_done = '0; mask_valid = 1'b0;
        alu_mask_ready = 1'b0; mfpu_mask_ready = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst issue_ready", 32'(issue_ready), 32'd1);
        check("rst occupancy", 32'(occupancy), 32'd0);
        check("rst mask_ready", 32'(mask_ready), 32'd0);
        check("rst valids", 32'({alu_mask_valid, mfpu_mask_valid}), 32'd0);
        check("rst error", 32'(error), 32'd0);

        // Single ALU owner, id 2, four beats
        tick();
        issue_valid = 1'b1; issue_fu = MaskFUAlu; issue_id = 3'd2;
        tick();
        issue_valid = 1'b0; alu_mask_ready = 1'b1; mask_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("alu beat valid", 32'(alu_mask_valid), 32'd1);
            check("alu beat mfpu idle", 32'(mfpu_mask_valid), 32'd0);
            check("alu beat ready", 32'(mask_ready), 32'd1);
            check("alu beat occ", 32'(occupancy), 32'd1);
            tick();
        end
        mask_valid = 1'b0; alu_done = 8'b0000_0100;
        @(negedge clk);
        check("alu done blank", 32'(mask_ready), 32'd0);
        tick();
        alu_done = '0;
        @(negedge clk);
        check("alu pop occ", 32'(occupancy), 32'd0);

        // Interleaved: ALU id 1 then MFPU id 3
        tick();
        issue_valid = 1'b1; issue_fu = MaskFUAlu; issue_id = 3'd1;
        tick();
        issue_fu = MaskFUMFpu; issue_id = 3'd3;
        tick();
        issue_valid = 1'b0; alu_mask_ready = 1'b1; mfpu_mask_ready = 1'b1; mask_valid = 1'b1;
        @(negedge clk);
        check("ilv occ", 32'(occupancy), 32'd2);
        check("ilv alu first", 32'({alu_mask_valid, mfpu_mask_valid}), 32'b10);
        tick();
        alu_done = 8'b0000_0010;
        @(negedge clk);
        check("ilv pop blank ready", 32'(mask_ready), 32'd0);
        check("ilv pop blank valids", 32'({alu_mask_valid, mfpu_mask_valid}), 32'd0);
        tick();
        alu_done = '0;
        @(negedge clk);
        check("ilv mfpu next", 32'({alu_mask_valid, mfpu_mask_valid}), 32'b01);
        check("ilv mfpu ready", 32'(mask_ready), 32'd1);
        tick();
        mfpu_mask_ready = 1'b0;
        @(negedge clk);
        check("ilv mfpu stall", 32'(mask_ready), 32'd0);
        tick();
        mask_valid = 1'b0; mfpu_done = 8'b0000_1000;
        tick();
        mfpu_done = '0;
        @(negedge clk);
        check("ilv drained", 32'(occupancy), 32'd0);

        // Non-head dones: other FU same id, same FU other id
        tick();
        issue_valid = 1'b1; issue_fu = MaskFUAlu; issue_id = 3'd1;
        tick();
        issue_valid = 1'b0; mfpu_done = 8'b0000_0010;
        tick();
        mfpu_done = '0; alu_done = 8'b0010_0000;
        tick();
        alu_done = '0;
        @(negedge clk);
        check("nonhead occ", 32'(occupancy), 32'd1);
        check("nonhead error", 32'(error), 32'd0);
        alu_done = 8'b0000_0010;
        tick();
        alu_done = '0;
        @(negedge clk);
        check("nonhead pop", 32'(occupancy), 32'd0);

        // Full queue, then refused issue alongside a head pop
        for (int i = 0; i < 4; i++) begin
            tick();
            issue_valid = 1'b1; issue_fu = 1'(i % 2); issue_id = 3'(i);
        end
        tick();
        issue_fu = MaskFUAlu; issue_id = 3'd4; alu_done = 8'b0000_0001;
        @(negedge clk);
        check("full occ", 32'(occupancy), 32'd4);
        check("full ready", 32'(issue_ready), 32'd0);
        tick();
        issue_valid = 1'b0; alu_done = '0;
        @(negedge clk);
        check("full after pop occ", 32'(occupancy), 32'd3);
        check("full after pop ready", 32'(issue_ready), 32'd1);

        // Reset while an MFPU beat is handshaking (head is MFPU id 1)
        mask_valid = 1'b1; mfpu_mask_ready = 1'b1;
        @(negedge clk);
        check("pre-reset mfpu beat", 32'({mfpu_mask_valid, mask_ready}), 32'b11);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("reset cycle ready", 32'(mask_ready), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post-reset occ", 32'(occupancy), 32'd0);
        check("post-reset valids", 32'({alu_mask_valid, mfpu_mask_valid}), 32'd0);
        check("post-reset ready", 32'(mask_ready), 32'd0);
        check("post-reset issue_ready", 32'(issue_ready), 32'd1);

        // Beat on an empty queue: sticky error only in the checking build
        tick();
        mask_valid = 1'b0;
        @(negedge clk);
`ifdef ARA_MASK_ROUTER_CHECK_EN
        check("empty beat error", 32'(error), 32'd1);
`else
        check("empty beat error", 32'(error), 32'd0);
`endif
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("error cleared", 32'(error), 32'd0);

        tick();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vfu_mask_router.md
# vfu_mask_router

Per-lane controller that owns the mask broadcast between the mask unit and the two vector functional units, the ALU and the MFPU. It records, in issue order, which FU owns each in-flight masked instruction. It then steers the mask unit's valid/ready handshake to that FU only, so that concurrent masked ALU and MFPU instructions never both accept the same mask beat. It sits in the lane's FU stage, between the lane sequencer, the mask unit and the two FUs.

## Interface
Parameters:
- `MaskQueueDepth`, default 4: number of in-flight masked instructions tracked; power of two, at least 2.
- `NrVInsn`, default from `ara_pkg`: width of the done vectors.

Ports (widths in bits):
- `clk_i`, input, 1: clock.
- `rst_i`, input, 1: reset, **synchronous, active-high**.
- `issue_valid_i`, input, 1: the sequencer issues a masked (vm=0) operation to an FU.
- `issue_fu_i`, input, 1: owner of the issued operation; 0 = ALU (`MaskFUAlu`), 1 = MFPU (`MaskFUMFpu`).
- `issue_id_i`, input, `vid_t`: instruction ID.
- `issue_ready_o`, output, 1: queue not full.
- `alu_vinsn_done_i`, input, `NrVInsn`: ALU done pulses.
- `mfpu_vinsn_done_i`, input, `NrVInsn`: MFPU done pulses.
- `mask_valid_i`, input, 1: mask unit beat valid. Mask data is not routed and stays broadcast.
- `mask_ready_o`, output, 1: beat accepted.
- `alu_mask_valid_o`, output, 1: beat valid toward the ALU.
- `alu_mask_ready_i`, input, 1: ALU accepts the beat.
- `mfpu_mask_valid_o`, output, 1: beat valid toward the MFPU.
- `mfpu_mask_ready_i`, input, 1: MFPU accepts the beat.
- `occupancy_o`, output, `$clog2(MaskQueueDepth)+1`: number of queued owners.
- `error_o`, output, 1: sticky protocol error (see Configuration).

## Operation
- **Owner queue.** The owner queue is a FIFO of `{fu, id}` entries.
  - Push on `issue_valid_i && issue_ready_o`.
  - The head is the current mask owner.
- **Routing when the queue is non-empty and not in a pop cycle.**
  - The head FU's valid output = `mask_valid_i`.
  - The other FU's valid output = 0.
  - `mask_ready_o` = head FU's ready input.
- **Routing when the queue is empty.** Both FU valid outputs = 0 and `mask_ready_o` = 0.
- **Pop.** Pop when the head FU's done vector has bit `head.id` set.
- **Pop-cycle blanking.** In the pop cycle, both FU valid outputs = 0 and `mask_ready_o` = 0. No beat can be misrouted to the outgoing owner.
- **Done pulses that do not match the head are ignored for routing.** This covers:
  - a done from the other FU;
  - a done for a different ID, including unmasked instructions.
- **Simultaneous push and pop.** Occupancy is unchanged, and the pushed entry is queued behind the new head.
- **Full queue.** `issue_ready_o` = 0 and there is no bypass, even if a pop happens in the same cycle.
- **Reset.** `rst_i` high at a clock edge empties the queue and clears `error_o`.
  - Any beat or issue presented in that cycle is discarded.
  - Reset mid-instruction abandons all queued ownership.
- **Occupancy width.** `occupancy_o` is `$clog2(MaskQueueDepth)+1` bits wide. Pointers wrap modulo `MaskQueueDepth`.

## Timing
- **Reset values:**
  - `issue_ready_o` = 1;
  - `mask_ready_o`, `alu_mask_valid_o` and `mfpu_mask_valid_o` = 0;
  - `occupancy_o` = 0;
  - `error_o` = 0.
- **Issue-to-route latency:** 1 cycle. An entry pushed at edge N becomes the head and is routable from cycle N+1 when the queue was empty.
- **Routing path:** combinational from `mask_valid_i`/`*_mask_ready_i` to the outputs, with no added beat latency.
- **Done-to-next-owner:** the done cycle is blanked, and the next entry is routed from the following cycle.
- **Handshake rule:** a beat transfers only when `mask_valid_i && mask_ready_o` in the same cycle.
- **Combinational loop:** `mask_ready_o` must not combinationally depend on `mask_valid_i`.

## Configuration
- **`ARA_MASK_ROUTER_CHECK_EN` defined:** `error_o` sets, and stays set until reset, when any of the following occurs:
  - a push while full;
  - a masked done pulse for an ID present in the queue but not at the head (out-of-order completion);
  - `mask_valid_i` high while the queue is empty.
  - Simulation assertions fire on the same conditions.
- **Not defined:** `error_o` is tied to 0 and no check logic is present.

## Structure
- **Shared package `ara_pkg`:**
  - `mask_owner_t` struct, fields `fu` (1 bit) and `id` (`vid_t`);
  - the existing `MaskFUAlu`/`MaskFUMFpu` constants are reused as the `fu` encoding.
- **Sub-module `mask_owner_fifo`:** a synchronous active-high-reset FIFO of `mask_owner_t`, with push, pop, head, full, empty and count. The routing and check logic stays in the top module.

## Test plan
- **Single ALU owner.** After reset, issue `{fu=0, id=2}`, then stream 4 beats with ALU ready high.
  - Expect `alu_mask_valid_o` pulses and `mfpu_mask_valid_o` = 0 throughout.
  - `alu_vinsn_done_i[2]` pops the queue and `occupancy_o` goes 1→0.
- **Interleaved owners.** Issue ALU id 1 and then MFPU id 3, with MFPU ready held high.
  - Beats go only to the ALU until `alu_vinsn_done_i[1]`.
  - That cycle shows `mask_ready_o` = 0.
  - Beats go to the MFPU from the next cycle.
- **Full queue.** Issue 4 owners with depth 4.
  - Expect `issue_ready_o` = 0 and `occupancy_o` = 4.
  - A 5th issue with a same-cycle head pop is still refused; `issue_ready_o` = 1 on the following cycle.
- **Non-head done.** With head ALU id 1, pulse `mfpu_vinsn_done_i[1]` and then `alu_vinsn_done_i[5]`.
  - The queue is unchanged.
  - With the check macro defined, `error_o` stays 0 unless id 5 is queued.
- **Reset mid-stream.** Assert `rst_i` for 1 cycle while a beat is handshaking with 3 owners queued.
  - Next cycle: `occupancy_o` = 0, both FU valid outputs = 0, `mask_ready_o` = 0, `issue_ready_o` = 1.
- **Check build.** With `ARA_MASK_ROUTER_CHECK_EN` defined, drive `mask_valid_i` = 1 on an empty queue.
  - `error_o` rises the next cycle and holds until `rst_i`.
